// File: rtl/object_plotter.sv
// Rectangle plotter for the VGA adapter: erases an object's old footprint in the
// background colour, then redraws it at its new position, one pixel per clock.
module object_plotter #(
    parameter int          MAX_X         = 159,
    parameter int          MAX_Y         = 119,
    parameter logic [2:0]  BG_COLOUR     = 3'b000,
    parameter logic [2:0]  BALL_COLOUR   = 3'b111,
    parameter logic [2:0]  PADDLE_COLOUR = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startPlot,
    input  logic [1:0] object,
    input  logic [7:0] newX,
    input  logic [6:0] newY,
    input  logic [7:0] oldX,
    input  logic [6:0] oldY,
    input  logic [7:0] sizeX,
    input  logic [6:0] sizeY,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

    state_t     state;
    logic [7:0] cx;
    logic [6:0] cy;
    logic [1:0] objR;
    logic [7:0] oldXR, newXR, sizeXR;
    logic [6:0] oldYR, newYR, sizeYR;

    logic       accept, pixelStep, drawPhase;
    logic [1:0] selObj;
    logic [7:0] selBaseX, selSizeX, curCx;
    logic [6:0] selBaseY, selSizeY, curCy;
    logic [8:0] pixX;
    logic [7:0] pixY;
    logic       clipped, zeroSize, lastCol, lastRow, hasDraw;
    logic [2:0] pixColour;

    // The accepting edge already emits erase pixel 0, so in IDLE the walk
    // logic is fed straight from the request inputs with zeroed counters.
    always_comb begin
        accept    = (state == IDLE) && startPlot && (object != 2'b11);
        drawPhase = (state == DRAW);
        pixelStep = accept || (state == ERASE) || (state == DRAW);
        if (state == IDLE) begin
            selObj   = object;
            selSizeX = sizeX;
            selSizeY = sizeY;
            selBaseX = oldX;
            selBaseY = oldY;
            curCx    = '0;
            curCy    = '0;
        end else begin
            selObj   = objR;
            selSizeX = sizeXR;
            selSizeY = sizeYR;
            selBaseX = drawPhase ? newXR : oldXR;
            selBaseY = drawPhase ? newYR : oldYR;
            curCx    = cx;
            curCy    = cy;
        end
        pixX      = {1'b0, selBaseX} + {1'b0, curCx};
        pixY      = {1'b0, selBaseY} + {1'b0, curCy};
        clipped   = (pixX > 9'(MAX_X)) || (pixY > 8'(MAX_Y));
        zeroSize  = (selSizeX == 8'd0) || (selSizeY == 7'd0);
        lastCol   = (curCx == selSizeX - 8'd1);
        lastRow   = (curCy == selSizeY - 7'd1);
        hasDraw   = (selObj[1] == 1'b0);
        pixColour = BG_COLOUR;
        if (drawPhase)
            pixColour = (selObj == 2'b00) ? BALL_COLOUR : PADDLE_COLOUR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cx      <= '0;
            cy      <= '0;
            objR    <= '0;
            oldXR   <= '0;
            oldYR   <= '0;
            newXR   <= '0;
            newYR   <= '0;
            sizeXR  <= '0;
            sizeYR  <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            plot    <= 1'b0;
            colour  <= BG_COLOUR;
            if (startPlot && state != IDLE)
                overrun <= 1'b1;

            // FINISH is the last pixel cycle; done shows while already in IDLE,
            // which lets a back-to-back request be accepted with no gap.
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        objR   <= object;
                        oldXR  <= oldX;
                        oldYR  <= oldY;
                        newXR  <= newX;
                        newYR  <= newY;
                        sizeXR <= sizeX;
                        sizeYR <= sizeY;
                        busy   <= 1'b1;
                        state  <= ERASE;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: ;
            endcase

            if (pixelStep) begin
                if (zeroSize) begin
                    state <= FINISH;
                end else begin
                    x      <= pixX[7:0];
                    y      <= pixY[6:0];
                    plot   <= ~clipped;
                    colour <= pixColour;
                    if (lastCol) begin
                        cx <= '0;
                        if (lastRow) begin
                            cy    <= '0;
                            state <= (drawPhase || !hasDraw) ? FINISH : DRAW;
                        end else begin
                            cy <= curCy + 7'd1;
                        end
                    end else begin
                        cx <= curCx + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_object_plotter.sv
// Directed table-driven bench for object_plotter with hand-computed pixel counts
// and completion cycles, plus sequences for overrun, back-to-back and reset.
module tb_object_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       startPlot;
    logic [1:0] object;
    logic [7:0] newX, oldX, sizeX;
    logic [6:0] newY, oldY, sizeY;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done, overrun;

    object_plotter dut (
        .clk(clk), .reset(reset), .startPlot(startPlot), .object(object),
        .newX(newX), .newY(newY), .oldX(oldX), .oldY(oldY),
        .sizeX(sizeX), .sizeY(sizeY),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] obj;
        int oX, oY, nX, nY, sX, sY;
        int expErase, expDraw, expDone, ovAt;
    } tv_t;

    tv_t vecs [8];
    int nVec = 0;
    int nMis = 0;

    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts at a negedge with the request driven; returns at the done cycle
    // (chain=1) or two cycles after it.
    task automatic runReq(input int i, input bit chain);
        tv_t v;
        int n, lim, doneAt, doneCnt, pixErr, busyErr, ovErr, eCnt, dCnt;
        int k, col, row, expCol;
        bit expPlot, inPhase, hasDraw;
        v = vecs[i];
        n = v.sX * v.sY;
        hasDraw = (v.obj < 2'd2);
        lim = chain ? v.expDone : v.expDone + 2;
        doneAt = 0; doneCnt = 0; pixErr = 0; busyErr = 0; ovErr = 0; eCnt = 0; dCnt = 0;
        startPlot = 1'b1; object = v.obj;
        oldX = 8'(v.oX); oldY = 7'(v.oY); newX = 8'(v.nX); newY = 7'(v.nY);
        sizeX = 8'(v.sX); sizeY = 7'(v.sY);
        @(negedge clk);
        for (int c = 1; c <= lim; c++) begin
            if (c > 1) @(negedge clk);
            inPhase = 1'b0; expPlot = 1'b0; col = 0; row = 0; expCol = 0;
            if (n > 0 && c <= n) begin
                k = c - 1; inPhase = 1'b1;
                col = v.oX + k % v.sX; row = v.oY + k / v.sX; expCol = 0;
            end else if (n > 0 && hasDraw && c <= 2 * n) begin
                k = c - n - 1; inPhase = 1'b1;
                col = v.nX + k % v.sX; row = v.nY + k / v.sX;
                expCol = (v.obj == 2'b00) ? 7 : 2;
            end
            if (inPhase) expPlot = (col <= 159) && (row <= 119);
            if (plot !== expPlot) pixErr++;
            else if (expPlot && (int'(x) != col || int'(y) != row || int'(colour) != expCol)) pixErr++;
            else if (!inPhase && colour !== 3'b000) pixErr++;
            if (pixErr == 1 && (plot !== expPlot || expPlot)) begin end
            if (plot === 1'b1 && colour == 3'b000) eCnt++;
            if (plot === 1'b1 && colour != 3'b000) dCnt++;
            if (busy !== (c <= v.expDone)) busyErr++;
            if (overrun !== (v.ovAt != 0 && c == v.ovAt + 1)) ovErr++;
            if (done === 1'b1) begin
                doneCnt++;
                if (doneAt == 0) doneAt = c;
            end
            if (c == 1) begin
                object = 2'b01; oldX = 8'd7; oldY = 7'd3; newX = 8'd9; newY = 7'd4;
                sizeX = 8'd2; sizeY = 7'd2;
            end
            startPlot = (v.ovAt != 0 && c == v.ovAt);
            if (startPlot) object = 2'b10;
        end
        chk($sformatf("v%0d pixel-errors", i), pixErr, 0);
        chk($sformatf("v%0d erase-plots", i), eCnt, v.expErase);
        chk($sformatf("v%0d draw-plots", i), dCnt, v.expDraw);
        chk($sformatf("v%0d done-cycle", i), doneAt, v.expDone);
        chk($sformatf("v%0d done-count", i), doneCnt, 1);
        chk($sformatf("v%0d busy-errors", i), busyErr, 0);
        chk($sformatf("v%0d overrun-errors", i), ovErr, 0);
    endtask

    initial begin
        //          obj    oX   oY   nX   nY  sX  sY  erase draw done ovAt
        vecs[0] = '{2'b00,  50, 118,  51, 117,  4,  4,   8,  12,  33, 0};
        vecs[1] = '{2'b01, 150, 117, 151, 117, 20,  1,  10,   9,  41, 0};
        vecs[2] = '{2'b10,  32,  10,  32,  10, 16, 10, 160,   0, 161, 0};
        vecs[3] = '{2'b00,  10,  20,  12,  22,  4,  2,   8,   8,  17, 6};
        vecs[4] = '{2'b00,   5,   5,   6,   6,  0,  4,   0,   0,   2, 0};
        vecs[5] = '{2'b01,   5,   5,   6,   6,  8,  0,   0,   0,   2, 0};
        vecs[6] = '{2'b00,  20,  30,  20,  30,  1,  1,   1,   1,   3, 0};
        vecs[7] = '{2'b10, 255,   0, 255,   0,  2,  2,   0,   0,   5, 0};

        reset = 1'b1; startPlot = 1'b0; object = 2'b11;
        oldX = '0; oldY = '0; newX = '0; newY = '0; sizeX = '0; sizeY = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {x, y, colour, plot, busy, done, overrun}, 0);
        reset = 1'b0;

        // object 11 must be ignored
        startPlot = 1'b1; object = 2'b11; sizeX = 8'd4; sizeY = 7'd4;
        @(negedge clk);
        chk("ignored busy", busy, 0);
        @(negedge clk);
        chk("ignored plot", {busy, plot, overrun}, 0);
        startPlot = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) runReq(i, 1'b0);

        // back-to-back: second request accepted at the edge ending done
        runReq(6, 1'b1);
        runReq(0, 1'b0);

        // reset during draw pixel 3 of a 4x4 ball
        startPlot = 1'b1; object = 2'b00; oldX = 8'd10; oldY = 7'd10;
        newX = 8'd11; newY = 7'd11; sizeX = 8'd4; sizeY = 7'd4;
        @(negedge clk);
        startPlot = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre-reset draw pixel", {x, y, colour, plot}, {8'd14, 7'd11, 3'b111, 1'b1});
        reset = 1'b1;
        @(negedge clk);
        chk("mid-reset plot/busy", {plot, busy, x}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset idle", {plot, busy, done}, 0);
        runReq(6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
